lsu_mem_stage: RTL

- Memory-stage load/store unit. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes the ALU result as the address and the store data from the M stage. Runs a request/grant/response transaction on the data-memory bus.
- Produces aligned, sign- or zero-extended read_dataM for the MEM/WB register.
- Asserts stallM to freeze upstream stages while an access is outstanding.

---
 rtl/lsu_mem_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- memory-stage load/store unit.
//
// Turns the M-stage load/store into a request/grant/response transaction on
// the data-memory bus. It formats store data and byte enables, and returns
// aligned, sign- or zero-extended load data to the MEM/WB register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   validM, flushM        M-stage instruction valid / kill (kill honoured in IDLE only)
//   mem_readM, mem_writeM load / store (both high -> store)
//   funct3M               size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALU_resultM           effective byte address
//   write_dataM           store data
//   read_dataM            registered, extended load data
//   stallM                combinational, high while the access is incomplete
//   fault_o               one-cycle pulse on misaligned address or illegal funct3
//   dmem_*                data-memory bus (req/we/addr/wdata/be out; gnt/rvalid/rdata in)
module lsu_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                validM,
  input  logic                flushM,
  input  logic                mem_readM,
  input  logic                mem_writeM,
  input  logic [2:0]          funct3M,
  input  logic [ADDR_W-1:0]   ALU_resultM,
  input  logic [DATA_W-1:0]   write_dataM,
  output logic [DATA_W-1:0]   read_dataM,
  output logic                stallM,
  output logic                fault_o,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_be,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [DATA_W-1:0]   dmem_rdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                fault_q, fault_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [1:0]          off_q, off_d;

  logic                op;
  logic                legal_f3;
  logic                aligned;
  logic [DATA_W-1:0]   fmt_wdata;
  logic [BE_W-1:0]     fmt_be;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [DATA_W-1:0]   ld_ext;

  // Access qualification and store formatting from the live M-stage inputs.
  always_comb begin
    op = validM & ~flushM & (mem_readM | mem_writeM);

    if (mem_writeM) legal_f3 = (funct3M == 3'b000) | (funct3M == 3'b001) | (funct3M == 3'b010);
    else            legal_f3 = (funct3M == 3'b000) | (funct3M == 3'b001) | (funct3M == 3'b010) |
                               (funct3M == 3'b100) | (funct3M == 3'b101);

    case (funct3M[1:0])
      2'b01:   aligned = ~ALU_resultM[0];
      2'b10:   aligned = (ALU_resultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase

    case (funct3M[1:0])
      2'b00: begin
        fmt_wdata = {4{write_dataM[7:0]}};
        fmt_be    = BE_W'(1) << ALU_resultM[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{write_dataM[15:0]}};
        fmt_be    = ALU_resultM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = write_dataM;
        fmt_be    = '1;
      end
    endcase
    if (!mem_writeM) fmt_be = '1;
  end

  // Load extraction uses the offset/size latched at request time, so the
  // M-stage inputs are free to change once the access has left IDLE.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    fault_d  = 1'b0;
    stallM   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op) begin
          if (legal_f3 && aligned) begin
            stallM   = 1'b1;
            state_d  = S_REQ;
            req_d    = 1'b1;
            we_d     = mem_writeM;
            addr_d   = {ALU_resultM[ADDR_W-1:2], 2'b00};
            wdata_d  = fmt_wdata;
            be_d     = fmt_be;
            funct3_d = funct3M;
            off_d    = ALU_resultM[1:0];
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        stallM = 1'b1;
        if (dmem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        stallM = 1'b1;
        if (dmem_rvalid) begin
          rdata_d = ld_ext;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
    end
  end

  assign read_dataM = rdata_q;
  assign fault_o    = fault_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

endmodule
